// File: rtl/mld_decode_sequencer.sv
// mld_decode_sequencer: buffers a serial received word and sequences the
// 15-bit majority-logic decoder through load, correction, capture and output.
// Ports: clk; reset (synchronous, active-low); flush (synchronous abort).
//   Source side : in_valid, in_bit, in_ready.
//   Decoder side: dec_load, dec_bit (to decoder), dec_vector (from decoder).
//   Sink side   : out_valid, out_ready, out_word.  busy is low only in FILL.
// Optional macro MLD_PREFETCH_EN: accept the next word into the buffer while
// the current one is being decoded or waiting at the output.
module mld_decode_sequencer #(
    parameter int N     = 15,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic         in_ready,
    output logic         dec_load,
    output logic         dec_bit,
    input  logic [N-1:0] dec_vector,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_word,
    output logic         busy
);

    typedef enum logic [2:0] {
        FILL,
        STREAM,
        DECODE,
        CAPTURE,
        OUT
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     data_buf;
    logic [N-1:0]     shifted_in;
    logic             accept;

    assign shifted_in = {data_buf[N-2:0], in_bit};
    assign accept     = in_valid & in_ready;

    assign dec_load  = (state == STREAM);
    assign dec_bit   = (state == STREAM) & data_buf[N-1];
    assign out_valid = (state == OUT);
    assign busy      = (state != FILL);

`ifdef MLD_PREFETCH_EN
    // Bits held in the buffer; reaches N only while waiting to stream.
    logic [CNT_W-1:0] fill_cnt;
    logic             buf_full;
    logic             full_next;

    assign buf_full  = (fill_cnt == CNT_W'(N));
    assign full_next = buf_full | (accept & (fill_cnt == LAST));
    assign in_ready  = (state == FILL) |
                       (((state == DECODE) | (state == CAPTURE) |
                         (state == OUT)) & ~buf_full);
`else
    assign in_ready = (state == FILL);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= FILL;
            cnt      <= '0;
            data_buf <= '0;
            out_word <= '0;
`ifdef MLD_PREFETCH_EN
            fill_cnt <= '0;
`endif
        end else if (flush) begin
            state    <= FILL;
            cnt      <= '0;
            data_buf <= '0;
`ifdef MLD_PREFETCH_EN
            fill_cnt <= '0;
`endif
        end else begin
            unique case (state)
                FILL: begin
                    if (accept) begin
                        data_buf <= shifted_in;
`ifdef MLD_PREFETCH_EN
                        if (fill_cnt == LAST) begin
                            fill_cnt <= '0;
                            state    <= STREAM;
                        end else begin
                            fill_cnt <= fill_cnt + CNT_W'(1);
                        end
`else
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= STREAM;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
`endif
                    end
                end
                STREAM: begin
                    // Shifting out leaves the buffer zeroed for the next word.
                    data_buf <= data_buf << 1;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= DECODE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DECODE: begin
`ifdef MLD_PREFETCH_EN
                    if (accept) begin
                        data_buf <= shifted_in;
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
`endif
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= CAPTURE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CAPTURE: begin
`ifdef MLD_PREFETCH_EN
                    if (accept) begin
                        data_buf <= shifted_in;
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
`endif
                    out_word <= dec_vector;
                    state    <= OUT;
                end
                OUT: begin
`ifdef MLD_PREFETCH_EN
                    if (accept) begin
                        data_buf <= shifted_in;
                        fill_cnt <= fill_cnt + CNT_W'(1);
                    end
                    if (out_ready) begin
                        cnt <= '0;
                        // A complete prefetched word skips FILL entirely.
                        if (full_next) begin
                            fill_cnt <= '0;
                            state    <= STREAM;
                        end else begin
                            state <= FILL;
                        end
                    end
`else
                    if (out_ready) begin
                        cnt   <= '0;
                        state <= FILL;
                    end
`endif
                end
                default: begin
                    state <= FILL;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/mld_decode_sequencer.md
Name: mld_decode_sequencer

Overview:
- Controller for the 15-bit multi-step majority-logic decoder.
- Accepts a received codeword one bit at a time over a valid/ready handshake and buffers it.
- Streams the buffered word into the decoder for 15 back-to-back cycles, then runs the 15-cycle correction pass, captures the decoded vector and presents it over a valid/ready output handshake.
- The decoder shifts on every clock and has no stall input, so this block isolates it from bursty sources and slow sinks.

Parameters:
- N, 15: codeword length; also the number of load cycles and the number of decode cycles.
- CNT_W, 4: width of the bit/cycle counter; must satisfy 2^CNT_W > N.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- flush  input  1  synchronous abort of the current word; active-high.
- in_valid  input  1  source has a received bit on in_bit.
- in_bit  input  1  received codeword bit.
- in_ready  output  1  block accepts in_bit this cycle.
- dec_load  output  1  drives the decoder's load input.
- dec_bit  output  1  drives the decoder's serial received-bit input.
- dec_vector  input  N  decoder's decoded_vector[0:14]; dec_vector[i] = decoded_vector[i].
- out_valid  output  1  out_word holds a decoded codeword.
- out_ready  input  1  sink accepts out_word.
- out_word  output  N  captured decoded codeword.
- busy  output  1  high in every state except FILL.

Behaviour:
- States:
  - FILL: collect bits into the buffer.
  - STREAM: shift the buffer into the decoder.
  - DECODE: decoder correction pass.
  - CAPTURE: sample the decoder output.
  - OUT: hold the result for the sink.
- Reset (reset=0 at a rising edge):
  - state=FILL, cnt=0, buf=0, out_word=0.
  - Resulting outputs: out_valid=0, dec_load=0, dec_bit=0, busy=0, in_ready=1.
  - Reset overrides every other input in every state, including mid-STREAM or mid-DECODE.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready: buf <= {buf[N-2:0], in_bit}; cnt increments.
  - When the 15th bit is accepted: cnt <= 0, go to STREAM.
  - The first accepted bit therefore sits in buf[N-1].
- STREAM (exactly N cycles):
  - dec_load=1, dec_bit=buf[N-1]; buf shifts left by 1 each cycle.
  - On cnt==N-1: cnt <= 0, go to DECODE.
  - At exit, the first accepted bit sits in dec_vector[14].
- DECODE (exactly N cycles):
  - dec_load=0, dec_bit=0.
  - On cnt==N-1: go to CAPTURE.
- CAPTURE (1 cycle): out_word <= dec_vector; go to OUT.
- OUT:
  - out_valid=1; out_word is stable.
  - On out_valid&out_ready: go to FILL, cnt <= 0.
  - The decoder keeps shifting while in OUT; the captured out_word is unaffected.
- Latency: out_valid is first high in the 32nd cycle after the edge that accepts the 15th input bit (15 STREAM + 15 DECODE + 1 CAPTURE, then OUT).
- dec_load and dec_bit are pure functions of registered state and buf.
- in_valid is ignored whenever in_ready=0.
- flush=1 at an edge, outside reset:
  - state=FILL, cnt=0, buf=0; out_valid drops.
  - Any partial input or in-flight word is discarded.
  - A bit presented in the same cycle is not accepted.
  - flush takes priority over every handshake in the same cycle.
- The counter never exceeds N-1.

Optional Feature:
- Macro: MLD_PREFETCH_EN.
- Defined:
  - The buffer is free once STREAM ends, so in_ready=1 in DECODE, CAPTURE and OUT as long as fewer than N bits are held.
  - A separate fill count tracks the prefetched bits.
  - On the OUT handshake: if the buffer is full, go directly to STREAM; otherwise go to FILL, keeping the bits already collected.
  - flush discards prefetched bits.
- Undefined: in_ready=1 only in FILL, and the fill count is not instantiated.

Test Plan:
- Reset with reset=0 for 3 cycles, then release -> out_valid=0, dec_load=0, busy=0, in_ready=1, out_word=15'h0000.
- 15 bits, all zero except the 5th accepted bit, presented with in_valid=1 every cycle; out_ready=1 -> dec_load high for exactly 15 cycles; out_valid rises in the 32nd cycle after the last accept; out_word=15'h0000; a single 1-cycle out_valid pulse.
- All-zero word with the 4th and 10th accepted bits set; in_valid toggling 1,0,1,0... -> only handshaken bits counted; out_word=15'h0000 (double error corrected).
- out_ready held 0 for 20 cycles in OUT -> out_valid held 1, out_word stable, in_ready=0 with the macro undefined; after out_ready=1, FILL is re-entered next cycle.
- flush asserted in DECODE cycle 7 -> next cycle state=FILL, busy=0, no out_valid; a following clean all-zero word gives out_word=15'h0000 with standard latency.
- With MLD_PREFETCH_EN: second word fully accepted during DECODE/OUT of the first -> STREAM starts the cycle after the first OUT handshake, with no FILL cycles in between.
